writeback_ctrl: RTL and testbench
=================================

Name: writeback_ctrl

Overview:
- Sequences the register-file write port for the single-issue RV32 core.
- Accepts one executed instruction per cycle and selects the ALU result, PC+4 or load data.
- Loads run a req/ack handshake with the data memory, stall upstream until data returns, then write back with byte or word formatting.
- Sits between the execute stage and the register file.

Parameters:
TIMEOUT_CYCLES, 64, cycles in WAIT_MEM without mem_ack before the load aborts; 0 disables the timeout
CNT_W, 8, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
nRst  in  1  asynchronous active-low reset
ex_valid  in  1  execute stage presents an instruction
ex_reg_write  in  1  instruction writes rd
ex_mem_to_reg  in  1  instruction is a load
ex_load_byte  in  1  load is byte (zero-extended), else word
ex_read_pc_4  in  1  write PC+4 (jal/jalr); overrides mem_to_reg
ex_rd  in  5  destination register
ex_alu_value  in  32  ALU result; also the load address
ex_pc_4_value  in  32  PC+4
mem_req  out  1  load request to data memory
mem_addr  out  32  load address
mem_ack  in  1  memory data valid, single-cycle pulse
mem_rdata  in  32  memory read data, valid with mem_ack
stall  out  1  upstream must hold its instruction
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
load_err  out  1  one-cycle pulse when a load times out

Behaviour:
- All outputs are registered. Reset clears the state to IDLE, clears the counter and drives every output to 0.
- stall = (state == WAIT_MEM). ex_* inputs are ignored while stall is 1.
- A load is defined as ex_mem_to_reg & ~ex_read_pc_4.
- IDLE, ex_valid, not a load:
  - Next cycle: rf_we = ex_reg_write & (ex_rd != 0), rf_waddr = ex_rd.
  - rf_wdata = ex_pc_4_value if ex_read_pc_4, else ex_alu_value.
  - Latency is 1 cycle; back-to-back instructions give one write per cycle.
- IDLE, ex_valid, load:
  - Latch rd, load_byte and the write flag.
  - Set mem_addr = ex_alu_value; next cycle mem_req = 1 and state moves to WAIT_MEM.
  - rf_we is 0 the next cycle.
- IDLE, ex_valid = 0: rf_we is 0 the next cycle.
- WAIT_MEM:
  - mem_req and mem_addr are held stable; the counter increments each cycle.
  - On mem_ack: the next cycle state is IDLE, mem_req = 0, the counter clears, and rf_we = latched write & (rd != 0).
  - rf_wdata = {24'b0, mem_rdata[7:0]} if load_byte, else mem_rdata.
  - stall drops in the same cycle as the write, and a new instruction may be accepted in that cycle.
- Timeout, TIMEOUT_CYCLES > 0:
  - Triggers when the counter reaches TIMEOUT_CYCLES-1 with no mem_ack.
  - Next cycle: load_err = 1 for exactly one cycle, no register write, mem_req = 0, state IDLE.
- mem_ack in the same cycle as the timeout: the ack wins; write normally, load_err stays 0.
- mem_ack outside WAIT_MEM is ignored.
- Load with rd = 0: the memory access still completes; rf_we stays 0.
- Reset mid-load: mem_req drops immediately, the pending write is discarded and stall clears.

Decomposition:
- Package wb_ctrl_pkg holds:
  - typedef enum {IDLE, WAIT_MEM} wb_state_t
  - typedef enum {SEL_ALU, SEL_PC4, SEL_MEM_WORD, SEL_MEM_BYTE} wb_sel_t
  - localparam REG_ADDR_W = 5, XLEN = 32
- One combinational sub-module, wb_format.
  - Inputs: wb_sel_t plus the ALU, PC+4 and memory values.
  - Output: formatted write data.
  - Instantiated once, ahead of the rf_wdata register.

Test Plan:
- Reset, then ALU op rd=5, alu=0xEEEEEEEE -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xEEEEEEEE; stall=0.
- jal rd=1, pc4=0xDDDDDDDD, mem_to_reg=1 -> rf_wdata=0xDDDDDDDD, mem_req never asserted.
- Byte load rd=3, addr=0x100; mem_ack after 4 cycles with 0xFFFFFFFF:
  - mem_req=1 and stall=1 for those 4 cycles, with mem_addr=0x100.
  - Next cycle rf_wdata=0x000000FF, rf_we=1 and stall=0.
- Word load with no ack, TIMEOUT_CYCLES=64 -> load_err pulses once 64 cycles after mem_req rises, with no rf_we and return to IDLE.
- Word load rd=0 with ack -> rf_we=0. Then an ALU op presented during stall is held and is written exactly once after the stall releases.
- nRst asserted mid-WAIT_MEM -> mem_req, stall and rf_we go to 0 immediately. A late mem_ack after release produces no write.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// wb_ctrl_pkg: shared types and widths for the writeback controller
package wb_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  typedef enum logic {IDLE, WAIT_MEM} wb_state_t;
  typedef enum logic [1:0] {SEL_ALU, SEL_PC4, SEL_MEM_WORD, SEL_MEM_BYTE} wb_sel_t;
endpackage

// File: rtl/wb_format.sv
// wb_format: selects and formats register-file write data
// Ports: sel chooses source; alu_value, pc_4_value, mem_value are candidates; wdata is the formatted result.
module wb_format
  import wb_ctrl_pkg::*;
(
  input  wb_sel_t              sel,
  input  logic [XLEN-1:0]      alu_value,
  input  logic [XLEN-1:0]      pc_4_value,
  input  logic [XLEN-1:0]      mem_value,
  output logic [XLEN-1:0]      wdata
);
  always_comb
    wdata = sel == SEL_PC4      ? pc_4_value :
            sel == SEL_MEM_WORD ? mem_value :
            sel == SEL_MEM_BYTE ? {{(XLEN-8){1'b0}}, mem_value[7:0]} :
                                  alu_value;
endmodule

// File: rtl/writeback_ctrl.sv
// writeback_ctrl: sequences the register-file write port, running loads through a req/ack memory handshake
// Ports: ex_* executed instruction in; mem_req/mem_addr/mem_ack/mem_rdata data-memory load handshake;
// stall holds upstream during a load; rf_we/rf_waddr/rf_wdata register-file write; load_err pulses on load timeout.
module writeback_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_load_byte,
  input  logic                  ex_read_pc_4,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_alu_value,
  input  logic [XLEN-1:0]       ex_pc_4_value,
  output logic                  mem_req,
  output logic [XLEN-1:0]       mem_addr,
  input  logic                  mem_ack,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  load_err
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  wb_state_t state, state_d;
  wb_sel_t sel;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [REG_ADDR_W-1:0] ld_rd, ld_rd_d, rf_waddr_d;
  logic [XLEN-1:0] mem_addr_d, fmt;
  logic ld_byte, ld_byte_d, ld_wr, ld_wr_d, mem_req_d, rf_we_d, load_err_d, is_load, timeout;
  assign is_load = ex_mem_to_reg & ~ex_read_pc_4;
  assign timeout = TIMEOUT_CYCLES != 0 && cnt == TO_LAST;
  assign stall = state == WAIT_MEM;
  assign sel = stall ? (ld_byte ? SEL_MEM_BYTE : SEL_MEM_WORD) : (ex_read_pc_4 ? SEL_PC4 : SEL_ALU);
  wb_format u_fmt (
    .sel        (sel),
    .alu_value  (ex_alu_value),
    .pc_4_value (ex_pc_4_value),
    .mem_value  (mem_rdata),
    .wdata      (fmt)
  );
  always_comb begin
    state_d    = state;
    cnt_d      = '0;
    ld_rd_d    = ld_rd;
    ld_byte_d  = ld_byte;
    ld_wr_d    = ld_wr;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr;
    load_err_d = 1'b0;
    if (state == IDLE) begin
      if (ex_valid && is_load) begin
        state_d    = WAIT_MEM;
        mem_req_d  = 1'b1;
        mem_addr_d = ex_alu_value;
        ld_rd_d    = ex_rd;
        ld_byte_d  = ex_load_byte;
        ld_wr_d    = ex_reg_write;
      end else if (ex_valid) begin
        rf_we_d    = ex_reg_write & (ex_rd != '0);
        rf_waddr_d = ex_rd;
      end
    end else if (mem_ack) begin
      // ack beats a coinciding timeout
      state_d    = IDLE;
      rf_we_d    = ld_wr & (ld_rd != '0);
      rf_waddr_d = ld_rd;
    end else if (timeout) begin
      state_d    = IDLE;
      load_err_d = 1'b1;
    end else begin
      mem_req_d = 1'b1;
      cnt_d     = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      state    <= IDLE;
      cnt      <= '0;
      ld_rd    <= '0;
      ld_byte  <= 1'b0;
      ld_wr    <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      load_err <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ld_rd    <= ld_rd_d;
      ld_byte  <= ld_byte_d;
      ld_wr    <= ld_wr_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      rf_we    <= rf_we_d;
      rf_waddr <= rf_waddr_d;
      rf_wdata <= fmt;
      load_err <= load_err_d;
    end
endmodule

// File: tb/tb_writeback_ctrl.sv
// tb_writeback_ctrl: vector table, directed load corner cases and randomized traffic against a transaction-level model
module tb_writeback_ctrl;
  logic clk = 0, nRst = 0;
  logic ex_valid = 0, ex_reg_write = 0, ex_mem_to_reg = 0, ex_load_byte = 0, ex_read_pc_4 = 0;
  logic [4:0] ex_rd = 0;
  logic [31:0] ex_alu_value = 0, ex_pc_4_value = 0, mem_rdata = 0;
  logic mem_ack = 0;
  logic mem_req, stall, rf_we, load_err;
  logic [31:0] mem_addr, rf_wdata;
  logic [4:0] rf_waddr;
  int total = 0, bad = 0;

  writeback_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
    .clk(clk), .nRst(nRst), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_load_byte(ex_load_byte), .ex_read_pc_4(ex_read_pc_4),
    .ex_rd(ex_rd), .ex_alu_value(ex_alu_value), .ex_pc_4_value(ex_pc_4_value),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, rw, mtr, lb, p4, input logic [4:0] rd, input logic [31:0] alu, pc4);
    ex_valid = v; ex_reg_write = rw; ex_mem_to_reg = mtr; ex_load_byte = lb; ex_read_pc_4 = p4;
    ex_rd = rd; ex_alu_value = alu; ex_pc_4_value = pc4;
  endtask

  typedef struct {
    logic v, rw, mtr, p4;
    logic [4:0] rd;
    logic [31:0] alu, pc4;
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd5,  32'hEEEEEEEE, 32'h00000004, 1'b1, 5'd5,  32'hEEEEEEEE};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd1,  32'h00000100, 32'hDDDDDDDD, 1'b1, 5'd1,  32'hDDDDDDDD};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  32'h11111111, 32'h0,        1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd7,  32'h22222222, 32'h0,        1'b0, 5'd0,  32'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd9,  32'h33333333, 32'h0,        1'b0, 5'd0,  32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd31, 32'h12345678, 32'h0,        1'b1, 5'd31, 32'h12345678};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd2,  32'h44444444, 32'h80000004, 1'b1, 5'd2,  32'h80000004};

    // reset state
    repeat (2) tick;
    chk("rst_stall", stall, 0); chk("rst_mem_req", mem_req, 0); chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rf_we", rf_we, 0); chk("rst_rf_waddr", rf_waddr, 0); chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_load_err", load_err, 0);
    nRst = 1;
    tick;

    // single-cycle ops, back to back
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].mtr, 1'b0, vecs[i].p4, vecs[i].rd, vecs[i].alu, vecs[i].pc4);
      tick;
      chk($sformatf("vec%0d_we", i), rf_we, vecs[i].we);
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].wa);
        chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].wd);
      end
      chk($sformatf("vec%0d_stall", i), stall, 0);
      chk($sformatf("vec%0d_mem_req", i), mem_req, 0);
    end

    // byte load, ack in the fourth wait cycle
    drive(1, 1, 1, 1, 0, 5'd3, 32'h100, 32'h0);
    tick;
    ex_valid = 0;
    chk("bl_we_accept", rf_we, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick;
      chk("bl_mem_req", mem_req, 1); chk("bl_stall", stall, 1); chk("bl_addr", mem_addr, 32'h100);
    end
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    tick;
    mem_ack = 0;
    chk("bl_we", rf_we, 1); chk("bl_waddr", rf_waddr, 3); chk("bl_wdata", rf_wdata, 32'h000000FF);
    chk("bl_stall_drop", stall, 0); chk("bl_req_drop", mem_req, 0);

    // word load with no ack times out
    begin
      int k = 0;
      bit we_seen = 0;
      drive(1, 1, 1, 0, 0, 5'd4, 32'h200, 32'h0);
      tick;
      ex_valid = 0;
      chk("to_req_rise", mem_req, 1);
      while (!load_err && k < 100) begin
        tick;
        k++;
        if (rf_we) we_seen = 1;
      end
      chk("to_latency", k, 64);
      chk("to_no_write", we_seen, 0);
      chk("to_req_drop", mem_req, 0); chk("to_stall_drop", stall, 0);
      tick;
      chk("to_err_pulse", load_err, 0);
    end

    // ack coinciding with the timeout cycle wins
    drive(1, 1, 1, 0, 0, 5'd8, 32'h300, 32'h0);
    tick;
    ex_valid = 0;
    repeat (63) tick;
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick;
    mem_ack = 0;
    chk("race_we", rf_we, 1); chk("race_wdata", rf_wdata, 32'hCAFEF00D); chk("race_err", load_err, 0);
    tick;
    chk("race_err_late", load_err, 0);

    // rd=0 load, then an ALU op held during the stall
    drive(1, 1, 1, 0, 0, 5'd0, 32'h400, 32'h0);
    tick;
    drive(1, 1, 0, 0, 0, 5'd6, 32'h66, 32'h0);
    repeat (2) begin
      tick;
      chk("hold_stall", stall, 1); chk("hold_we", rf_we, 0);
    end
    mem_ack = 1; mem_rdata = 32'h12345678;
    tick;
    mem_ack = 0;
    chk("rd0_we", rf_we, 0); chk("rd0_stall", stall, 0);
    tick;
    ex_valid = 0;
    chk("held_we", rf_we, 1); chk("held_waddr", rf_waddr, 6); chk("held_wdata", rf_wdata, 32'h66);
    tick;
    chk("held_once", rf_we, 0);

    // reset mid-load, then a late ack
    drive(1, 1, 1, 0, 0, 5'd9, 32'h500, 32'h0);
    tick;
    ex_valid = 0;
    tick;
    chk("mid_req", mem_req, 1);
    nRst = 0;
    #1;
    chk("mid_rst_req", mem_req, 0); chk("mid_rst_stall", stall, 0); chk("mid_rst_we", rf_we, 0);
    tick;
    nRst = 1;
    mem_ack = 1; mem_rdata = 32'hBADBAD00;
    tick;
    mem_ack = 0;
    chk("late_ack_we", rf_we, 0); chk("late_ack_stall", stall, 0);
    tick;

    // randomized traffic against a transaction-level model
    begin
      bit busy = 0, p_b = 0, p_w = 0, e_we, e_err;
      int n = 0;
      logic [4:0] p_rd = 0, e_wa;
      logic [31:0] p_addr = 0, e_wd;
      for (int c = 0; c < 600; c++) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)), $urandom, $urandom);
        mem_ack = $urandom_range(0, 5) == 0;
        mem_rdata = $urandom;
        e_we = 0; e_err = 0; e_wa = 0; e_wd = 0;
        if (!busy) begin
          if (ex_valid && ex_mem_to_reg && !ex_read_pc_4) begin
            busy = 1; n = 0; p_rd = ex_rd; p_b = ex_load_byte; p_w = ex_reg_write; p_addr = ex_alu_value;
          end else if (ex_valid && ex_reg_write && ex_rd != 0) begin
            e_we = 1; e_wa = ex_rd; e_wd = ex_read_pc_4 ? ex_pc_4_value : ex_alu_value;
          end
        end else begin
          n++;
          if (mem_ack) begin
            busy = 0;
            if (p_w && p_rd != 0) begin
              e_we = 1; e_wa = p_rd; e_wd = p_b ? (mem_rdata & 32'hFF) : mem_rdata;
            end
          end else if (n == 64) begin
            busy = 0; e_err = 1;
          end
        end
        tick;
        chk("rnd_we", rf_we, e_we);
        if (e_we) begin
          chk("rnd_waddr", rf_waddr, e_wa);
          chk("rnd_wdata", rf_wdata, e_wd);
        end
        chk("rnd_stall", stall, busy);
        chk("rnd_mem_req", mem_req, busy);
        chk("rnd_load_err", load_err, e_err);
        if (busy) chk("rnd_mem_addr", mem_addr, p_addr);
      end
      mem_ack = 0;
      ex_valid = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
